pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder.
- Decodes the IF/ID instruction into the 8-bit control word plus branch/jump strobes, and registers control and register fields into the ID/EX stage.
- Detects load-use hazards and inserts a configurable number of bubbles.
- Flushes IF/ID on a taken branch or jump for a configurable number of cycles.
- Sits between the IF/ID register and the EX stage of the 5-stage pipeline; drives PC and IF/ID write enables.

Parameters:
- INSTR_W, 32, instruction width. Opcode is [INSTR_W-1 -: 6], rs [25:21], rt [20:16], rd [15:11].
- REG_AW, 5, register address width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard. Range 1..3.
- FLUSH_CYCLES, 1, cycles ifid_flush_o is held per taken branch/jump. Range 1..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- instr_i  in  INSTR_W  IF/ID instruction
- instr_valid_i  in  1  IF/ID holds a real instruction
- branch_taken_i  in  1  ID-stage rs==rt compare result
- branch_o  out  1  decoded beq, qualified by instr_valid_i and RUN state
- jump_o  out  1  decoded j, qualified likewise
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID update enable
- ifid_flush_o  out  1  zero IF/ID on next edge
- idex_ctrl_o  out  8  registered control word
- idex_rs_o, idex_rt_o, idex_rd_o  out  REG_AW  registered register fields
- idex_valid_o  out  1  ID/EX holds a real instruction
- illegal_o  out  1  current instruction has an undefined opcode

Behaviour:
- Decode table, opcode -> ctrl:
  - 000000 -> 8'b10000001
  - 001101 -> 8'b10001010
  - 100011 -> 8'b11101100
  - 101011 -> 8'b00011100
  - 000100 -> 8'b00001100, branch
  - 000010 -> 8'b00000000, jump
  - any other opcode -> ctrl 0, illegal_o=1
- Decode is fully combinational with defaults assigned first: no latches, no blocking/non-blocking mixing.
- ctrl[5] is MemRead.
- FSM states: RUN, STALL, FLUSH. 2-bit down-counter cnt.
- Reset (rst_n low, asynchronous):
  - state=RUN, cnt=0, idex_ctrl_o=0, idex_rs/rt/rd=0, idex_valid_o=0.
  - Combinational outputs pc_write_o, ifid_write_o, ifid_flush_o, branch_o, jump_o, illegal_o are forced 0 while rst_n is low.
- hazard = instr_valid_i & idex_valid_o & idex_ctrl_o[5] & idex_rt_o!=0 & (idex_rt_o==rs | (uses_rt & idex_rt_o==rt)).
  - uses_rt is 1 for R-type, sw, beq.
- RUN, hazard:
  - pc_write_o=0, ifid_write_o=0.
  - ID/EX loads a bubble: ctrl 0, valid 0.
  - branch_o and jump_o are 0.
  - If STALL_CYCLES>1: cnt=STALL_CYCLES-1, next state STALL. Otherwise remain in RUN.
- RUN, no hazard:
  - pc_write_o=1, ifid_write_o=1.
  - ID/EX loads decode and fields; valid = instr_valid_i & ~illegal.
  - If (branch & branch_taken_i) | jump: ifid_flush_o=1 in this cycle. If FLUSH_CYCLES>1: cnt=FLUSH_CYCLES-1, next state FLUSH.
- STALL:
  - Same outputs as RUN-hazard.
  - Decrement cnt; at cnt==1 move to RUN.
  - The held instruction issues in the first RUN cycle, where hazard is re-evaluated and is now false.
- FLUSH:
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  - ID/EX loads a bubble. Decrement cnt; at cnt==1 move to RUN.
- Simultaneous hazard and taken branch: hazard wins. The branch is re-evaluated with a fresh branch_taken_i once the stall ends.
- Latency: decode to idex_* is 1 cycle.
- Reset mid-STALL or mid-FLUSH: immediate return to RUN with all registers cleared.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output trap_o (1 bit) and register trap_pc_cnt (8 bits), which counts RUN cycles since reset.
  - An illegal opcode in RUN sets sticky trap_o and freezes the counter.
  - Once trap_o is set, pc_write_o and ifid_write_o stay 0 until reset.
- When not defined:
  - The illegal instruction issues as a bubble (valid 0).
  - illegal_o remains combinational only; no ports are added.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J
  - the six CTRL_* 8-bit constants
  - bit index CTRL_MEMREAD=5
  - the state enum
- Natural sub-module: ctrl_decode. Pure combinational opcode -> {ctrl, branch, jump, uses_rt, illegal}. Reused by any future single-cycle datapath.

Test Plan:
- Reset, then 0x010B5020 with valid=1 -> next cycle idex_ctrl_o=8'h81, rs=8, rt=11, rd=10, idex_valid_o=1.
- 0x8D280000 then 0x010B5020, STALL_CYCLES=1:
  - the second instruction's cycle has pc_write_o=0, ifid_write_o=0, idex_valid_o=0 next edge;
  - the add issues one cycle later with ctrl 8'h81.
- Same sequence with STALL_CYCLES=3 -> exactly 3 bubble cycles, then the add issues.
- beq 0x11090004 with branch_taken_i=1, FLUSH_CYCLES=2 -> branch_o=1, ifid_flush_o=1 for 2 consecutive cycles, beq ctrl 8'h0C issues. With branch_taken_i=0 -> no flush.
- Opcode 6'b111111:
  - illegal_o=1, ctrl bubble.
  - With CTRL_ILLEGAL_TRAP_EN: trap_o sticks at 1, pc_write_o stays 0, until rst_n pulses low.
- rst_n dropped during the 2nd cycle of a STALL_CYCLES=3 stall -> all idex_* are 0 immediately. After release, state is RUN and pc_write_o=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the ID-stage pipeline control unit:
//   - opcode encodings (OP_*)
//   - 8-bit control words per opcode (CTRL_*)
//   - bit index of MemRead inside the control word
//   - FSM state encoding for pipe_ctrl_unit
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] CTRL_RTYPE = 8'b10000001;
  localparam logic [7:0] CTRL_ORI   = 8'b10001010;
  localparam logic [7:0] CTRL_LW    = 8'b11101100;
  localparam logic [7:0] CTRL_SW    = 8'b00011100;
  localparam logic [7:0] CTRL_BEQ   = 8'b00001100;
  localparam logic [7:0] CTRL_J     = 8'b00000000;

  localparam int CTRL_MEMREAD = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode decoder, shared with single-cycle datapaths.
// Ports:
//   opcode   in  6  instruction opcode field
//   ctrl     out 8  control word (0 for undefined opcodes)
//   branch   out 1  opcode is beq
//   jump     out 1  opcode is j
//   uses_rt  out 1  instruction reads rt as a source (R-type, sw, beq)
//   illegal  out 1  opcode is not defined
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [7:0] ctrl,
  output logic       branch,
  output logic       jump,
  output logic       uses_rt,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    branch  = 1'b0;
    jump    = 1'b0;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl    = CTRL_RTYPE;
        uses_rt = 1'b1;
      end
      OP_ORI: ctrl = CTRL_ORI;
      OP_LW:  ctrl = CTRL_LW;
      OP_SW: begin
        ctrl    = CTRL_SW;
        uses_rt = 1'b1;
      end
      OP_BEQ: begin
        ctrl    = CTRL_BEQ;
        branch  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J: begin
        ctrl = CTRL_J;
        jump = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// ID-stage control for a 5-stage pipeline: decodes the IF/ID instruction,
// registers control word and register fields into ID/EX, stalls on load-use
// hazards (STALL_CYCLES bubbles) and flushes IF/ID after a taken branch or
// jump (FLUSH_CYCLES cycles).
// Optional build macro CTRL_ILLEGAL_TRAP_EN adds a sticky illegal-opcode
// trap (trap_o) that freezes PC and IF/ID until reset.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_i, instr_valid_i  IF/ID instruction and its valid flag
//   branch_taken_i          ID-stage rs==rt compare
//   branch_o, jump_o        decoded beq / j, only when issuing in RUN
//   pc_write_o              PC update enable
//   ifid_write_o            IF/ID update enable
//   ifid_flush_o            zero IF/ID on the next edge
//   idex_ctrl_o             registered control word
//   idex_rs/rt/rd_o         registered register fields
//   idex_valid_o            ID/EX holds a real instruction
//   illegal_o               current opcode is undefined
//   trap_o                  (CTRL_ILLEGAL_TRAP_EN only) sticky trap flag
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic              instr_valid_i,
  input  logic              branch_taken_i,
  output logic              branch_o,
  output logic              jump_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic [7:0]        idex_ctrl_o,
  output logic [REG_AW-1:0] idex_rs_o,
  output logic [REG_AW-1:0] idex_rt_o,
  output logic [REG_AW-1:0] idex_rd_o,
  output logic              idex_valid_o,
  output logic              illegal_o
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              trap_o
`endif
);

  // Instruction fields
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign opcode = instr_i[INSTR_W-1 -: 6];
  assign rs     = REG_AW'(instr_i[25:21]);
  assign rt     = REG_AW'(instr_i[20:16]);
  assign rd     = REG_AW'(instr_i[15:11]);

  logic [7:0] dec_ctrl;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_uses_rt;
  logic       dec_illegal;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .branch  (dec_branch),
    .jump    (dec_jump),
    .uses_rt (dec_uses_rt),
    .illegal (dec_illegal)
  );

  // State and ID/EX registers
  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [7:0]        idex_ctrl_reg;
  logic [REG_AW-1:0] idex_rs_reg, idex_rt_reg, idex_rd_reg;
  logic              idex_valid_reg;

  // Load-use hazard: the load in EX writes a register the current
  // instruction reads. $0 never creates a dependency.
  logic hazard;
  assign hazard = instr_valid_i & idex_valid_reg & idex_ctrl_reg[CTRL_MEMREAD]
                & (idex_rt_reg != '0)
                & ((idex_rt_reg == rs) | (dec_uses_rt & (idex_rt_reg == rt)));

  // Redirect only considered when the instruction actually issues in RUN.
  logic redirect;
  assign redirect = instr_valid_i & ((dec_branch & branch_taken_i) | dec_jump);

  // Trap logic
  logic trap_active;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       trap_reg;
  logic       trap_set;
  logic [7:0] trap_pc_cnt_reg;

  assign trap_set    = (state_reg == ST_RUN) & instr_valid_i & dec_illegal & ~trap_reg;
  // The trapping instruction itself also holds the PC so it stays inspectable.
  assign trap_active = trap_reg | trap_set;
  assign trap_o      = trap_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_reg        <= 1'b0;
      trap_pc_cnt_reg <= '0;
    end else begin
      if (trap_set)
        trap_reg <= 1'b1;
      if (!trap_active && state_reg == ST_RUN)
        trap_pc_cnt_reg <= trap_pc_cnt_reg + 8'd1;
    end
  end
`else
  assign trap_active = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FSM: next state. The RUN cycle that detects a hazard/redirect is itself
  // the first bubble/flush cycle, so the extra states cover the remainder.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (hazard) begin
          if (STALL_CYCLES > 1) begin
            state_next = ST_STALL;
            cnt_next   = 2'(STALL_CYCLES - 1);
          end
        end else if (redirect) begin
          if (FLUSH_CYCLES > 1) begin
            state_next = ST_FLUSH;
            cnt_next   = 2'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_STALL, ST_FLUSH: begin
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1)
          state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM: outputs. Everything is held at 0 while reset is asserted.
  logic issue;

  always_comb begin
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    branch_o     = 1'b0;
    jump_o       = 1'b0;
    illegal_o    = 1'b0;
    issue        = 1'b0;
    if (rst_n) begin
      illegal_o = dec_illegal;
      case (state_reg)
        ST_RUN: begin
          if (!hazard) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            issue        = 1'b1;
            branch_o     = instr_valid_i & dec_branch;
            jump_o       = instr_valid_i & dec_jump;
            ifid_flush_o = redirect;
          end
        end
        ST_FLUSH: begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
        end
        default: ;
      endcase
      if (trap_active) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end
    end
  end

  // ID/EX register: decoded instruction when issuing, otherwise an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_reg  <= '0;
      idex_rs_reg    <= '0;
      idex_rt_reg    <= '0;
      idex_rd_reg    <= '0;
      idex_valid_reg <= 1'b0;
    end else if (issue) begin
      idex_ctrl_reg  <= dec_ctrl;
      idex_rs_reg    <= rs;
      idex_rt_reg    <= rt;
      idex_rd_reg    <= rd;
      idex_valid_reg <= instr_valid_i & ~dec_illegal;
    end else begin
      idex_ctrl_reg  <= '0;
      idex_rs_reg    <= '0;
      idex_rt_reg    <= '0;
      idex_rd_reg    <= '0;
      idex_valid_reg <= 1'b0;
    end
  end

  assign idex_ctrl_o  = idex_ctrl_reg;
  assign idex_rs_o    = idex_rs_reg;
  assign idex_rt_o    = idex_rt_reg;
  assign idex_rd_o    = idex_rd_reg;
  assign idex_valid_o = idex_valid_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit. Two instances share the stimulus:
//   u_a : STALL_CYCLES=1, FLUSH_CYCLES=2 (table-driven vectors)
//   u_b : STALL_CYCLES=3, FLUSH_CYCLES=1 (hand-written multi-cycle sequences)
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid;
  logic        taken;

  always #5 clk = ~clk;

  logic       a_br, a_j, a_pcw, a_ifw, a_fl, a_ill, a_v;
  logic [7:0] a_ctrl;
  logic [4:0] a_rs, a_rt, a_rd;
  logic       b_br, b_j, b_pcw, b_ifw, b_fl, b_ill, b_v;
  logic [7:0] b_ctrl;
  logic [4:0] b_rs, b_rt, b_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic a_trap, b_trap;
`endif

  pipe_ctrl_unit #(.INSTR_W(32), .REG_AW(5), .STALL_CYCLES(1), .FLUSH_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid),
    .branch_taken_i(taken), .branch_o(a_br), .jump_o(a_j), .pc_write_o(a_pcw),
    .ifid_write_o(a_ifw), .ifid_flush_o(a_fl), .idex_ctrl_o(a_ctrl),
    .idex_rs_o(a_rs), .idex_rt_o(a_rt), .idex_rd_o(a_rd), .idex_valid_o(a_v),
    .illegal_o(a_ill)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .trap_o(a_trap)
`endif
  );

  pipe_ctrl_unit #(.INSTR_W(32), .REG_AW(5), .STALL_CYCLES(3), .FLUSH_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid),
    .branch_taken_i(taken), .branch_o(b_br), .jump_o(b_j), .pc_write_o(b_pcw),
    .ifid_write_o(b_ifw), .ifid_flush_o(b_fl), .idex_ctrl_o(b_ctrl),
    .idex_rs_o(b_rs), .idex_rt_o(b_rt), .idex_rd_o(b_rd), .idex_valid_o(b_v),
    .illegal_o(b_ill)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .trap_o(b_trap)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic t);
    instr = ins;
    valid = v;
    taken = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // comb = {pc_write, ifid_write, ifid_flush, branch, jump, illegal} for u_a
  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        t;
    logic [5:0]  comb;
    logic [7:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        idv;
  } vec_t;

  vec_t vecs[21];
  int   bubbles;
  logic issued;

  initial begin
    // add $10,$8,$11 / lw $8,0($9) / beq $8,$9 / j / illegal / ori / sw
    vecs[0]  = '{32'h010B5020, 1'b1, 1'b0, 6'b110000, 8'h81, 5'd8, 5'd11, 5'd10, 1'b1};
    vecs[1]  = '{32'h8D280000, 1'b1, 1'b0, 6'b110000, 8'hEC, 5'd9, 5'd8,  5'd0,  1'b1};
    vecs[2]  = '{32'h010B5020, 1'b1, 1'b0, 6'b000000, 8'h00, 5'd0, 5'd0,  5'd0,  1'b0};
    vecs[3]  = '{32'h010B5020, 1'b1, 1'b0, 6'b110000, 8'h81, 5'd8, 5'd11, 5'd10, 1'b1};
    vecs[4]  = '{32'h11090004, 1'b1, 1'b1, 6'b111100, 8'h0C, 5'd8, 5'd9,  5'd0,  1'b1};
    vecs[5]  = '{32'h010B5020, 1'b1, 1'b0, 6'b111000, 8'h00, 5'd0, 5'd0,  5'd0,  1'b0};
    vecs[6]  = '{32'h11090004, 1'b1, 1'b0, 6'b110100, 8'h0C, 5'd8, 5'd9,  5'd0,  1'b1};
    vecs[7]  = '{32'h08000010, 1'b1, 1'b0, 6'b111010, 8'h00, 5'd0, 5'd0,  5'd0,  1'b1};
    vecs[8]  = '{32'h010B5020, 1'b1, 1'b0, 6'b111000, 8'h00, 5'd0, 5'd0,  5'd0,  1'b0};
    vecs[9]  = '{32'hFC000000, 1'b1, 1'b0, 6'b110001, 8'h00, 5'd0, 5'd0,  5'd0,  1'b0};
    vecs[10] = '{32'h010B5020, 1'b0, 1'b0, 6'b110000, 8'h81, 5'd8, 5'd11, 5'd10, 1'b0};
    vecs[11] = '{32'h8D280000, 1'b1, 1'b0, 6'b110000, 8'hEC, 5'd9, 5'd8,  5'd0,  1'b1};
    vecs[12] = '{32'h35280000, 1'b1, 1'b0, 6'b110000, 8'h8A, 5'd9, 5'd8,  5'd0,  1'b1};
    vecs[13] = '{32'h8D280000, 1'b1, 1'b0, 6'b110000, 8'hEC, 5'd9, 5'd8,  5'd0,  1'b1};
    vecs[14] = '{32'hAD280000, 1'b1, 1'b0, 6'b000000, 8'h00, 5'd0, 5'd0,  5'd0,  1'b0};
    vecs[15] = '{32'hAD280000, 1'b1, 1'b0, 6'b110000, 8'h1C, 5'd9, 5'd8,  5'd0,  1'b1};
    vecs[16] = '{32'h8D200000, 1'b1, 1'b0, 6'b110000, 8'hEC, 5'd9, 5'd0,  5'd0,  1'b1};
    vecs[17] = '{32'h00000020, 1'b1, 1'b0, 6'b110000, 8'h81, 5'd0, 5'd0,  5'd0,  1'b1};
    vecs[18] = '{32'h8D280000, 1'b1, 1'b0, 6'b110000, 8'hEC, 5'd9, 5'd8,  5'd0,  1'b1};
    vecs[19] = '{32'h11090004, 1'b1, 1'b1, 6'b000000, 8'h00, 5'd0, 5'd0,  5'd0,  1'b0};
    vecs[20] = '{32'h11090004, 1'b1, 1'b0, 6'b110100, 8'h0C, 5'd8, 5'd9,  5'd0,  1'b1};

    // Reset state, with a valid instruction present to show outputs are forced low
    rst_n = 1'b0;
    drive(32'h010B5020, 1'b1, 1'b1);
    next_cycle();
    check("reset comb a", {a_pcw, a_ifw, a_fl, a_br, a_j, a_ill}, 6'b0);
    check("reset idex a", {a_ctrl, a_rs, a_rt, a_rd, a_v}, 24'h0);
    check("reset comb b", {b_pcw, b_ifw, b_fl, b_br, b_j, b_ill}, 6'b0);
    check("reset idex b", {b_ctrl, b_rs, b_rt, b_rd, b_v}, 24'h0);
    rst_n = 1'b1;

    // Table-driven vectors against u_a
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ins, vecs[i].v, vecs[i].t);
      #1;
      check($sformatf("vec%0d comb", i), {a_pcw, a_ifw, a_fl, a_br, a_j, a_ill}, vecs[i].comb);
      next_cycle();
      check($sformatf("vec%0d idex_ctrl", i), a_ctrl, vecs[i].ctrl);
      check($sformatf("vec%0d idex_rs", i), a_rs, vecs[i].rs);
      check($sformatf("vec%0d idex_rt", i), a_rt, vecs[i].rt);
      check($sformatf("vec%0d idex_rd", i), a_rd, vecs[i].rd);
      check($sformatf("vec%0d idex_valid", i), a_v, vecs[i].idv);
      $display("vec%0d instr=%h valid=%b taken=%b -> ctrl=%h valid=%b", i,
               vecs[i].ins, vecs[i].v, vecs[i].t, a_ctrl, a_v);
    end

    // Fresh start for the multi-cycle sequences
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    next_cycle();

    // u_b: lw then dependent add -> 3 bubbles, then the add issues
    drive(32'h8D280000, 1'b1, 1'b0);
    next_cycle();
    drive(32'h010B5020, 1'b1, 1'b0);
    bubbles = 0;
    issued  = 1'b0;
    for (int k = 0; k < 8 && !issued; k++) begin
      #1;
      if (b_pcw) issued = 1'b1;
      else bubbles++;
      next_cycle();
      if (!issued) check($sformatf("stall3 bubble%0d valid", bubbles), b_v, 1'b0);
    end
    check("stall3 bubble count", bubbles, 3);
    check("stall3 add ctrl", b_ctrl, 8'h81);
    check("stall3 add valid", b_v, 1'b1);
    $display("stall3 sequence: %0d bubbles, then ctrl=%h", bubbles, b_ctrl);

    // u_b: jump with FLUSH_CYCLES=1 flushes exactly one cycle
    drive(32'h08000010, 1'b1, 1'b0);
    #1 check("flush1 jump flush", {b_fl, b_j}, 2'b11);
    next_cycle();
    drive(32'h010B5020, 1'b1, 1'b0);
    #1 check("flush1 after flush", {b_fl, b_pcw}, 2'b01);
    next_cycle();
    $display("flush1 sequence: jump flush one cycle");

    // u_b: reset during the 2nd cycle of a 3-cycle stall
    drive(32'h8D280000, 1'b1, 1'b0);
    next_cycle();
    drive(32'h010B5020, 1'b1, 1'b0);
    #1 check("rst-stall hazard pc_write", b_pcw, 1'b0);
    next_cycle();
    #1 check("rst-stall in stall pc_write", b_pcw, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("rst-stall idex b", {b_ctrl, b_rs, b_rt, b_rd, b_v}, 24'h0);
    #1 rst_n = 1'b1;
    #1 check("rst-stall back to RUN", {b_pcw, b_ifw}, 2'b11);
    next_cycle();
    check("rst-stall add issues", {b_ctrl, b_v}, {8'h81, 1'b1});
    $display("reset mid-stall: idex cleared, RUN restored");

    // u_a: reset in the middle of a 2-cycle flush clears a loaded ID/EX
    drive(32'h11090004, 1'b1, 1'b1);
    #1 check("rst-flush beq strobes", {a_br, a_fl}, 2'b11);
    next_cycle();
    check("rst-flush beq issued", {a_ctrl, a_v}, {8'h0C, 1'b1});
    drive(32'h010B5020, 1'b1, 1'b0);
    #1 check("rst-flush 2nd flush cycle", a_fl, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst-flush idex a", {a_ctrl, a_rs, a_rt, a_rd, a_v}, 24'h0);
    check("rst-flush comb forced", {a_pcw, a_ifw, a_fl}, 3'b000);
    #1 rst_n = 1'b1;
    #1 check("rst-flush back to RUN", {a_pcw, a_fl}, 2'b10);
    next_cycle();
    $display("reset mid-flush: idex cleared, RUN restored");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog: the sequences above are bounded, this guards against a stuck clock
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
